video_capture: RTL
==================

VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-003 Parameter FIFO_DEPTH, default 16, output FIFO entries, power of two, at least 4.
REQ-004 Port clk, input, 1, pixel clock; all logic is on its rising edge.
REQ-005 Port rstn, input, 1, synchronous active-low reset.
REQ-006 Port capture_en, input, 1, enables frame capture.
REQ-007 Port vid_red, vid_green, vid_blue, input, 8 each, pixel colour components.
REQ-008 Port vid_de, input, 1, active-high data enable (pixel valid, not blanked).
REQ-009 Port vid_vsync, input, 1, active-high vertical sync.
REQ-010 Port m_tdata, output, 32, bits [7:0] red, [15:8] green, [23:16] blue, [31:24] zero.
REQ-011 Port m_tvalid, output, 1; m_tready, input, 1.
REQ-012 Port m_tlast, output, 1, marks the last pixel of a frame.
REQ-013 Port m_tuser, output, 1, marks the first pixel of a frame.
REQ-014 Port err_overflow, output, 1, sticky FIFO-overflow flag.
REQ-015 Port err_size, output, 1, sticky frame-size error flag.
REQ-016 Port frame_cnt, output, 16, count of frames completed with tlast; wraps at 65535 to 0.

Function
REQ-017 vid_* inputs are registered once; all decisions below use the registered copies.
- REQ-018 Frame start is a rising edge of the registered vsync, judged against its previous sample.
REQ-019 FSM states and transitions:
- IDLE: go to ARMED when capture_en=1 and a frame start occurs.
- ARMED: go to CAPTURE on the first DE=1; that pixel carries tuser=1 and pixel counter=0.
- CAPTURE: each DE=1 pixel is written to the FIFO and increments the counter.
- DROP: nothing is written.
REQ-020 In CAPTURE, the pixel written while counter = H_VISIBLE*V_VISIBLE-1 carries tlast=1; the FSM then goes to ARMED if capture_en=1, otherwise IDLE.
REQ-021 Frame start while in CAPTURE (short frame): set err_size, write nothing extra, go to ARMED (or IDLE if capture_en=0).
REQ-022 DE=1 in ARMED after a completed frame, before the next frame start (excess pixels): set err_size; those pixels are not written.
- REQ-023 ARMED only accepts a first pixel after a frame start has been seen since entering ARMED; an excess-pixel flag tracks this.
REQ-024 capture_en=0 in CAPTURE does not abort; the current frame finishes normally.
REQ-025 A write while the FIFO is full: pixel discarded, err_overflow set, FSM goes to DROP.
- Full is the pre-edge occupancy count equal to FIFO_DEPTH; a same-cycle read does not free space.
REQ-026 DROP exits on the next frame start, to ARMED (capture_en=1) or IDLE.
- The truncated frame receives no tlast and does not increment frame_cnt.
REQ-027 The FIFO is first-word fall-through; m_tvalid equals FIFO not-empty.
- An entry pops on m_tvalid & m_tready.
- m_tdata/m_tlast/m_tuser are stable while m_tvalid=1 and m_tready=0.
REQ-028 Latency: a pixel presented on vid_* before clock edge E appears with m_tvalid=1 after edge E+2 when the FIFO was empty.
REQ-029 frame_cnt increments on the edge where a tlast entry is popped.
REQ-030 The pixel counter is ceil(log2(H_VISIBLE*V_VISIBLE)) bits wide and never wraps; it resets to 0 on every ARMED-to-CAPTURE transition.

Reset
REQ-031 While rstn=0 at an edge:
- FSM to IDLE, FIFO emptied, counters 0.
- m_tvalid, m_tlast, m_tuser, err_overflow, err_size and frame_cnt all 0.
- The vsync edge detector's previous sample is cleared to 0.
REQ-032 Reset mid-frame discards FIFO contents; capture resumes only after a new frame start.

Verification (H_VISIBLE=4, V_VISIBLE=2, FIFO_DEPTH=4 unless noted)
REQ-033 Nominal frame: stimulus capture_en=1, m_tready=1, vsync pulse, then 2 lines of 4 DE pixels with values 0x010203 upward.
- Response: 8 beats with tdata=0x00030201 first, tuser on beat 0, tlast on beat 7, frame_cnt=1.
REQ-034 Backpressure: m_tready=0 during the nominal frame.
- Response: beats 0-3 held stable and pixel 4 dropped with err_overflow=1.
- After m_tready=1: exactly 4 beats, no tlast, frame_cnt=0.
- The next full frame is delivered intact, with tuser and tlast.
REQ-035 Short frame: a vsync pulse after 5 pixels.
- Response: err_size=1, 5 beats without tlast.
- The following 8-pixel frame is delivered with tuser on its first beat.
REQ-036 Excess pixels: 10 DE pixels between vsyncs.
- Response: 8 beats with tlast on the 8th; pixels 9-10 not output; err_size=1.
REQ-037 Enable gating: capture_en set to 0 at pixel 3, then the frame continues.
- Response: the full frame is delivered with tlast.
- The next frame produces no beats; the FSM stays IDLE.
REQ-038 Reset mid-frame: rstn=0 for 1 cycle after pixel 2.
- Response: m_tvalid=0 and flags 0 the next cycle.
- Remaining pixels are ignored until the next vsync, then a normal frame follows.

Source files
------------

// File: rtl/video_capture.sv
// rtl/video_capture.sv - video frame capture into a first-word fall-through stream FIFO

module video_capture_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  output logic         rd_valid,
  output logic [W-1:0] rd_data,
  input  logic         rd_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Full is judged on the pre-edge count, so a same-cycle pop never makes room.
  assign full     = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign rd_data  = mem_q[rd_ptr_q];
  assign push     = wr_en & ~full;
  assign pop      = rd_valid & rd_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

module video_capture #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        capture_en,
  input  logic [7:0]  vid_red,
  input  logic [7:0]  vid_green,
  input  logic [7:0]  vid_blue,
  input  logic        vid_de,
  input  logic        vid_vsync,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        err_overflow,
  output logic        err_size,
  output logic [15:0] frame_cnt
);
  localparam int NPIX  = H_VISIBLE * V_VISIBLE;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPIX - 1);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DROP} state_t;

  state_t           state_q, state_d;
  logic [7:0]       red_q, red_d, green_q, green_d, blue_q, blue_d;
  logic             de_q, de_d, vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_seen_q, start_seen_d;
  logic             wr_en_q, wr_en_d;
  logic [25:0]      wr_data_q, wr_data_d;
  logic             err_overflow_q, err_overflow_d, err_size_q, err_size_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;

  logic             fifo_full, fifo_valid;
  logic [25:0]      fifo_data;
  logic             frame_start, overflow, take, is_last;
  logic [CNT_W-1:0] pix_idx;
  state_t           after_frame;

  video_capture_fifo #(.W(26), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en_q),
    .wr_data  (wr_data_q),
    .full     (fifo_full),
    .rd_valid (fifo_valid),
    .rd_data  (fifo_data),
    .rd_ready (m_tready)
  );

  assign m_tdata      = {8'h00, fifo_data[23:0]};
  assign m_tvalid     = fifo_valid;
  assign m_tlast      = fifo_valid & fifo_data[24];
  assign m_tuser      = fifo_valid & fifo_data[25];
  assign err_overflow = err_overflow_q;
  assign err_size     = err_size_q;
  assign frame_cnt    = frame_cnt_q;

  always_comb begin
    red_d          = vid_red;
    green_d        = vid_green;
    blue_d         = vid_blue;
    de_d           = vid_de;
    vsync_d        = vid_vsync;
    vsync_prev_d   = vsync_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    start_seen_d   = start_seen_q;
    wr_en_d        = 1'b0;
    wr_data_d      = wr_data_q;
    err_overflow_d = err_overflow_q;
    err_size_d     = err_size_q;
    frame_cnt_d    = frame_cnt_q + 16'(m_tvalid & m_tready & m_tlast);

    frame_start = vsync_q & ~vsync_prev_q;
    overflow    = wr_en_q & fifo_full;
    after_frame = capture_en ? ARMED : IDLE;
    pix_idx     = (state_q == ARMED) ? '0 : cnt_q;
    is_last     = (pix_idx == LAST_IDX);
    take        = 1'b0;

    // An overflowing write truncates the frame whatever the FSM was doing.
    if (overflow) begin
      err_overflow_d = 1'b1;
      state_d        = DROP;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_en && frame_start) begin
            state_d      = ARMED;
            start_seen_d = 1'b1;
          end
        end
        ARMED: begin
          if (frame_start) start_seen_d = 1'b1;
          if (de_q) begin
            if (start_seen_q || frame_start) take = 1'b1;
            else err_size_d = 1'b1;
          end
        end
        CAPTURE: begin
          if (frame_start) begin
            err_size_d   = 1'b1;
            state_d      = after_frame;
            start_seen_d = 1'b1;
          end else if (de_q) begin
            take = 1'b1;
          end
        end
        DROP: begin
          if (frame_start) begin
            state_d      = after_frame;
            start_seen_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase

      if (take) begin
        wr_en_d   = 1'b1;
        wr_data_d = {state_q == ARMED, is_last, blue_q, green_q, red_q};
        if (is_last) begin
          state_d      = after_frame;
          start_seen_d = 1'b0;
          cnt_d        = '0;
        end else begin
          state_d = CAPTURE;
          cnt_d   = pix_idx + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      red_q          <= '0;
      green_q        <= '0;
      blue_q         <= '0;
      de_q           <= 1'b0;
      vsync_q        <= 1'b0;
      vsync_prev_q   <= 1'b0;
      cnt_q          <= '0;
      start_seen_q   <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_data_q      <= '0;
      err_overflow_q <= 1'b0;
      err_size_q     <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      red_q          <= red_d;
      green_q        <= green_d;
      blue_q         <= blue_d;
      de_q           <= de_d;
      vsync_q        <= vsync_d;
      vsync_prev_q   <= vsync_prev_d;
      cnt_q          <= cnt_d;
      start_seen_q   <= start_seen_d;
      wr_en_q        <= wr_en_d;
      wr_data_q      <= wr_data_d;
      err_overflow_q <= err_overflow_d;
      err_size_q     <= err_size_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end
endmodule
